// File: rtl/mips_fetch_pkg.sv
// Shared constants for the MIPS instruction fetch path: address and
// instruction widths, memory depth, fetch FSM state codes and the NOP word.
package mips_fetch_pkg;

  localparam int ADDR_W    = 10;
  localparam int INSTR_W   = 32;
  localparam int MEM_DEPTH = 81;
  localparam int CNT_W     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'b0;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Program counter and fetch sequencer sitting in front of the instruction
// memory. The memory has a one-cycle registered read, so every address
// issued here comes back as an instruction on the following cycle. The
// in-flight register remembers which address that returning word belongs to.
module instruction_fetch_unit #(
  parameter int ADDR_W    = mips_fetch_pkg::ADDR_W,
  parameter int INSTR_W   = mips_fetch_pkg::INSTR_W,
  parameter int MEM_DEPTH = mips_fetch_pkg::MEM_DEPTH,
  parameter int CNT_W     = mips_fetch_pkg::CNT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] instrucao,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               busy,
  output logic               err,
  output logic [CNT_W-1:0]   instr_count
);

  import mips_fetch_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_valid_q, inflight_valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic start_oob;
  logic redirect_oob;

  assign start_oob    = (start_addr >= DEPTH_ADDR);
  assign redirect_oob = (redirect_addr >= DEPTH_ADDR);

  // Next fetch state: halt/range errors first, then redirect, then stall, then sequential advance.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    err_d            = err_q;

    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d          = ST_HALT;
          inflight_valid_d = 1'b0;
        end else if (redirect) begin
          inflight_valid_d = 1'b0;
          if (redirect_oob) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            pc_d = redirect_addr;
          end
        end else if (!stall) begin
          inflight_pc_d    = pc_q;
          inflight_valid_d = 1'b1;
          // The last word is fetched once; pc parks there instead of wrapping.
          if (pc_q >= LAST_ADDR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end

      ST_IDLE, ST_HALT: begin
        if (start) begin
          inflight_valid_d = 1'b0;
          if (start_oob) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            pc_d    = start_addr;
          end
        end else if (!stall) begin
          // A final instruction left over from end-of-memory drains once decode takes it.
          inflight_valid_d = 1'b0;
        end
      end

      default: begin
        state_d          = ST_IDLE;
        inflight_valid_d = 1'b0;
      end
    endcase
  end

  // Count instructions decode actually consumes; sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (inflight_valid_q && !stall && !redirect && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Fetch state registers, cleared immediately when reset_n drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      pc_q             <= '0;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      err_q            <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      err_q            <= err_d;
      count_q          <= count_d;
    end
  end

  // While stalled, re-issue the held address so memory keeps presenting the same word.
  assign address     = (state_q == ST_RUN && stall && inflight_valid_q) ? inflight_pc_q : pc_q;
  assign instr_valid = inflight_valid_q;
  assign instr_pc    = inflight_pc_q;
  assign instr_out   = inflight_valid_q ? instrucao : INSTR_W'(NOP_INSTR);
  assign busy        = (state_q == ST_RUN);
  assign err         = err_q;
  assign instr_count = count_q;

endmodule
